// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding and
// slice-count derivations used to size the slice counter.
package multi_cycle_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int nslice(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit counter to be legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_cycle_adder_if.sv
// Start/done handshake and operand/result bundle of the multi-cycle adder.
// The requester drives through master; the adder sits on slave.
interface multi_cycle_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/multi_cycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; each bit is a full adder made of two
// half adders whose carries are ORed.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g_xy;
    logic [CHUNK-1:0] g_pc;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign p[i]    = x[i] ^ y[i];
        assign g_xy[i] = x[i] & y[i];
        assign s[i]    = p[i] ^ c[i];
        assign g_pc[i] = p[i] & c[i];
        assign c[i+1]  = g_xy[i] | g_pc[i];
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/multi_cycle_adder.sv
// Sequential adder/subtractor: one CHUNK-bit slice per clock from the LSB,
// carry held in a register between slices, start/done handshake.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_cycle_adder_if.slave   bus
);

    localparam int NSLICE = nslice(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NSLICE);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("multi_cycle_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             co_sl;
    logic             last;
    logic             accept;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x  (a_sl),
        .y  (b_sl),
        .ci (carry_q),
        .s  (s_sl),
        .co (co_sl)
    );

    assign last   = (cnt_q == CW'(NSLICE - 1));
    assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    // Subtraction is A + ~B + 1: invert B here, force carry-in.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = s_sl;
                    end
                end
                carry_d = co_sl;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = ST_DONE;
                    cout_d  = co_sl;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand registers are only read in RUN, which always follows a load.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed bench for multi_cycle_adder: a 16/4 instance and an 8/8 instance.
module tb_multi_cycle_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    multi_cycle_adder_if #(.WIDTH(16)) bus16 ();
    multi_cycle_adder_if #(.WIDTH(8))  bus8 ();

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_done16(output int bc, output bit ok);
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus16.done) begin
                ok = 1'b1;
                break;
            end
            if (bus16.busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic op16(input string tag, input logic s, input logic c,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] es, input logic ec, input logic eo);
        int bc;
        bit ok;
        @(negedge clk);
        bus16.start = 1'b1; bus16.sub = s; bus16.cin = c; bus16.a = x; bus16.b = y;
        @(negedge clk);
        bus16.start = 1'b0;
        wait_done16(bc, ok);
        chk({tag, ".done"}, 32'(ok), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(bc), 32'd4);
        chk({tag, ".sum"}, 32'(bus16.sum), 32'(es));
        chk({tag, ".cout"}, 32'(bus16.cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(bus16.ovf), 32'(eo));
        @(negedge clk);
        chk({tag, ".done_once"}, 32'(bus16.done), 32'd0);
    endtask

    initial begin
        int  bc;
        bit  ok;
        int  n_done;

        bus16.start = 1'b0; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.a = '0; bus16.b = '0;
        bus8.start  = 1'b0; bus8.sub  = 1'b0; bus8.cin  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus16.busy), 32'd0);
        chk("rst.done", 32'(bus16.done), 32'd0);
        chk("rst.sum",  32'(bus16.sum),  32'd0);
        chk("rst.cout", 32'(bus16.cout), 32'd0);
        chk("rst.ovf",  32'(bus16.ovf),  32'd0);
        rst = 1'b0;

        op16("add_00ff", 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
        op16("add_ffff", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        op16("add_7fff", 1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1);
        op16("sub_5_7",  1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        op16("sub_8000", 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

        // Start during RUN is ignored; start in the DONE cycle is accepted.
        @(negedge clk);
        bus16.start = 1'b1; bus16.sub = 1'b0; bus16.cin = 1'b0;
        bus16.a = 16'h1234; bus16.b = 16'h1111;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
        @(negedge clk);
        bus16.start = 1'b0;
        wait_done16(bc, ok);
        chk("b2b.first_done", 32'(ok), 32'd1);
        chk("b2b.first_sum", 32'(bus16.sum), 32'h2345);
        bus16.start = 1'b1; bus16.a = 16'h0001; bus16.b = 16'h0001;
        @(negedge clk);
        bus16.start = 1'b0; bus16.a = 16'hAAAA; bus16.b = 16'h5555;
        chk("b2b.accepted_busy", 32'(bus16.busy), 32'd1);
        chk("b2b.sum_cleared", 32'(bus16.sum), 32'd0);
        wait_done16(bc, ok);
        chk("b2b.second_done", 32'(ok), 32'd1);
        chk("b2b.second_busy_cycles", 32'(bc), 32'd4);
        chk("b2b.second_sum", 32'(bus16.sum), 32'h0002);
        @(negedge clk);

        // Reset on the second RUN cycle aborts the operation.
        bus16.start = 1'b1; bus16.a = 16'h1234; bus16.b = 16'h1111;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 32'(bus16.busy), 32'd0);
        chk("abort.sum",  32'(bus16.sum),  32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus16.done) n_done++;
            @(negedge clk);
        end
        chk("abort.no_done", 32'(n_done), 32'd0);
        rst = 1'b1; bus16.start = 1'b1; bus16.a = 16'h0009; bus16.b = 16'h0009;
        @(negedge clk);
        rst = 1'b0; bus16.start = 1'b0;
        chk("rst_start.busy", 32'(bus16.busy), 32'd0);
        @(negedge clk);
        chk("rst_start.busy2", 32'(bus16.busy), 32'd0);
        op16("add_3_4", 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("hold.sum", 32'(bus16.sum), 32'h0007);

        // Single-slice configuration: one busy cycle then done.
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.a = 8'h80; bus8.b = 8'h80;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("w8.busy", 32'(bus8.busy), 32'd1);
        chk("w8.done_early", 32'(bus8.done), 32'd0);
        @(negedge clk);
        chk("w8.busy_off", 32'(bus8.busy), 32'd0);
        chk("w8.done", 32'(bus8.done), 32'd1);
        chk("w8.sum",  32'(bus8.sum),  32'h00);
        chk("w8.cout", 32'(bus8.cout), 32'd1);
        chk("w8.ovf",  32'(bus8.ovf),  32'd1);
        @(negedge clk);
        chk("w8.done_once", 32'(bus8.done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
